// File: rtl/conv_output_collector_pkg.sv
// Shared types and helpers for the conv output collector: default word width,
// width helper and the collector state encoding.
package conv_output_collector_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Bits needed to hold 0..n-1, never below 1 so a one-word frame still has an address bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/conv_planar_addr_gen.sv
// Channel-planar write address generator: walks a pixel-major, channel-minor
// stream and yields ch*IMAGE_SIZE + pix using a running plane base instead of a multiply.
module conv_planar_addr_gen
  import conv_output_collector_pkg::*;
#(
  parameter int IMAGE_SIZE      = 306 * 306,
  parameter int CHANNEL_NUM_OUT = 1,
  parameter int ADDR_WIDTH      = clog2(IMAGE_SIZE * CHANNEL_NUM_OUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam int CH_W  = clog2(CHANNEL_NUM_OUT);
  localparam int PIX_W = clog2(IMAGE_SIZE);

  localparam logic [CH_W-1:0]       CH_LAST    = CH_W'(CHANNEL_NUM_OUT - 1);
  localparam logic [PIX_W-1:0]      PIX_LAST   = PIX_W'(IMAGE_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] PLANE_STEP = ADDR_WIDTH'(IMAGE_SIZE);

  logic [CH_W-1:0]       ch_cnt;
  logic [PIX_W-1:0]      pix_cnt;
  logic [ADDR_WIDTH-1:0] ch_base;
  logic                  ch_wrap;

  assign ch_wrap = (ch_cnt == CH_LAST);
  assign last    = ch_wrap && (pix_cnt == PIX_LAST);
  assign addr    = ch_base + ADDR_WIDTH'(pix_cnt);

  // The last word of a frame wraps every counter back to zero on its own step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_cnt  <= '0;
      pix_cnt <= '0;
      ch_base <= '0;
    end else if (clear) begin
      ch_cnt  <= '0;
      pix_cnt <= '0;
      ch_base <= '0;
    end else if (step) begin
      if (ch_wrap) begin
        ch_cnt  <= '0;
        ch_base <= '0;
        pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PIX_W'(1);
      end else begin
        ch_cnt  <= ch_cnt + CH_W'(1);
        ch_base <= ch_base + PLANE_STEP;
      end
    end
  end

endmodule

// File: rtl/conv_output_collector.sv
// Sink for the conv pipeline output stream: writes each word into a channel-planar
// buffer and holds the completed frame until the consumer acknowledges it.
module conv_output_collector
  import conv_output_collector_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH     = 306,
  parameter int IMAGE_HEIGHT    = 306,
  parameter int CHANNEL_NUM_OUT = 1,
  parameter int IMAGE_SIZE      = IMAGE_WIDTH * IMAGE_HEIGHT,
  parameter int ADDR_WIDTH      = clog2(IMAGE_SIZE * CHANNEL_NUM_OUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  frame_ack,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overflow_err
);

  state_t                state;
  logic                  step;
  logic                  clear;
  logic                  last;
  logic [ADDR_WIDTH-1:0] addr;

  // Words are only consumed while the buffer is not being held for the consumer.
  assign step  = valid_in && (state != ST_DONE);
  assign clear = frame_ack && (state == ST_DONE);

  conv_planar_addr_gen #(
    .IMAGE_SIZE      (IMAGE_SIZE),
    .CHANNEL_NUM_OUT (CHANNEL_NUM_OUT),
    .ADDR_WIDTH      (ADDR_WIDTH)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .clear (clear),
    .addr  (addr),
    .last  (last)
  );

  // Write port and status flags are registered together so frame_done lines up with the final write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      mem_wr_en    <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (valid_in) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= addr;
            mem_wr_data <= pxl_in;
            if (last) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else begin
              state <= ST_COLLECT;
              busy  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (valid_in) overflow_err <= 1'b1;
          if (frame_ack) begin
            state      <= ST_IDLE;
            frame_done <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
